// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types used by the fetch stage and its consumers.
// Holds the IF/ID stage register layout and the fetch FSM state encoding.
package rv32i_types;

    // Fetch FSM: issue a request, wait for the response, hold until decode takes it.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    // Payload handed from fetch to decode; fields are meaningful only when valid_s=1.
    typedef struct packed {
        logic        valid_s;
        logic [31:0] pc_s;
        logic [31:0] pc_next_s;
        logic [63:0] order_s;
    } if_id_stage_reg_t;

    localparam logic [3:0]  RMASK_REQ  = 4'hF;
    localparam logic [3:0]  RMASK_IDLE = 4'h0;
    localparam logic [31:0] PC_STEP    = 32'd4;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding word request at a time, hands the
// response to decode and advances the PC and retire order when decode accepts.
// Optional macro FETCH_PIPE_EN: the advance cycle also issues the next request,
// giving back-to-back fetch against a 1-cycle memory.
//
// Handshake: move=1 while if_id_reg.valid_s=1 transfers the instruction to
// decode in that cycle; move while valid_s=0 has no effect. imem_resp is a
// one-cycle pulse honoured only in S_WAIT.
module if_fetch
    import rv32i_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             move,
    output logic [31:0]      imem_addr,
    output logic [3:0]       imem_rmask,
    input  logic [31:0]      imem_rdata,
    input  logic             imem_resp,
    output if_id_stage_reg_t if_id_reg,
    output logic             fetch_busy,
    output fetch_state_t     dbg_state
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_pc;
    logic [31:0]  w_pc_next;
    logic [31:0]  w_pc_plus4;
    logic [63:0]  r_order;
    logic [63:0]  w_order_next;
    logic         w_advance;
    logic [31:0]  w_unused_rdata;

    // The instruction word is consumed by decode directly from memory.
    assign w_unused_rdata = imem_rdata;
    assign dbg_state      = r_state;

    // Next-state, memory request and decode payload; outputs forced idle in reset.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_order_next = r_order;
        w_pc_plus4   = r_pc + PC_STEP;
        w_advance    = 1'b0;
        imem_addr    = 32'd0;
        imem_rmask   = RMASK_IDLE;
        fetch_busy   = 1'b0;
        if_id_reg    = '0;

        case (r_state)
            S_REQ: begin
                // Any stray response here belongs to an abandoned request.
                imem_addr    = r_pc;
                imem_rmask   = RMASK_REQ;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                fetch_busy = 1'b1;
                if (imem_resp) begin
                    if_id_reg.valid_s = 1'b1;
                    w_advance         = move;
                    if (!move) begin
                        w_state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if_id_reg.valid_s = 1'b1;
                w_advance         = move;
            end
            default: begin
                w_state_next = S_REQ;
            end
        endcase

        if (if_id_reg.valid_s) begin
            if_id_reg.pc_s      = r_pc;
            if_id_reg.pc_next_s = w_pc_plus4;
            if_id_reg.order_s   = r_order;
        end

        if (w_advance) begin
            w_pc_next    = w_pc_plus4;
            w_order_next = r_order + 64'd1;
`ifdef FETCH_PIPE_EN
            imem_addr    = w_pc_plus4;
            imem_rmask   = RMASK_REQ;
            w_state_next = S_WAIT;
`else
            w_state_next = S_REQ;
`endif
        end

        if (!rst_n) begin
            imem_addr  = 32'd0;
            imem_rmask = RMASK_IDLE;
            fetch_busy = 1'b0;
            if_id_reg  = '0;
        end
    end

    // State, PC and retire-order registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
            r_order <= 64'd0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_order <= w_order_next;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a scoreboard queue records {pc, pc_next, order}
// when a request is seen and is popped when the response makes valid_s rise.
// Second instance uses RESET_PC=32'hFFFFFFFC for the PC wrap case.
module tb_if_fetch;
    import rv32i_types::*;

    localparam logic [31:0] RST_PC_A = 32'h1eceb000;
    localparam logic [31:0] RST_PC_B = 32'hFFFFFFFC;
`ifdef FETCH_PIPE_EN
    localparam int THR_EXP = 4;
`else
    localparam int THR_EXP = 8;
`endif

    logic             clk;
    logic             rst_n;
    logic             move;
    logic             imem_resp;
    logic [31:0]      imem_addr;
    logic [3:0]       imem_rmask;
    logic [31:0]      imem_rdata;
    if_id_stage_reg_t if_id_reg;
    logic             fetch_busy;
    fetch_state_t     dbg_state;

    logic             move_b;
    logic             resp_b;
    logic [31:0]      addr_b;
    logic [3:0]       rmask_b;
    if_id_stage_reg_t if_id_b;
    logic             busy_b;
    fetch_state_t     dbg_state_b;

    int               n_assert;
    int               n_fail;
    int               cyc;
    logic [31:0]      m_pc;
    logic [63:0]      m_order;
    logic [127:0]     exp_q[$];

    if_fetch #(.RESET_PC(RST_PC_A)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .move       (move),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .if_id_reg  (if_id_reg),
        .fetch_busy (fetch_busy),
        .dbg_state  (dbg_state)
    );

    if_fetch #(.RESET_PC(RST_PC_B)) u_dut_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .move       (move_b),
        .imem_addr  (addr_b),
        .imem_rmask (rmask_b),
        .imem_rdata (imem_rdata),
        .imem_resp  (resp_b),
        .if_id_reg  (if_id_b),
        .fetch_busy (busy_b),
        .dbg_state  (dbg_state_b)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive inputs at the falling edge, then sample 1 ns later.
    task automatic step(input logic mv, input logic rsp);
        @(negedge clk);
        move      = mv;
        imem_resp = rsp;
        cyc++;
        #1;
    endtask

    // Entered at a sample point where a request for m_pc must be visible.
    task automatic do_fetch(input int lat, input int hold);
        logic [127:0] e;
        e = '0;
        chk("req_rmask", imem_rmask, 4'hF);
        chk("req_addr", imem_addr, m_pc);
`ifndef FETCH_PIPE_EN
        chk("req_valid", if_id_reg.valid_s, 1'b0);
        chk("req_busy", fetch_busy, 1'b0);
`endif
        exp_q.push_back({m_pc, m_pc + 32'd4, m_order});
        for (int i = 1; i < lat; i++) begin
            step(1'b1, 1'b0);
            chk("wait_valid", if_id_reg.valid_s, 1'b0);
            chk("wait_busy", fetch_busy, 1'b1);
            chk("wait_rmask", imem_rmask, 4'h0);
            chk("wait_addr", imem_addr, 32'd0);
        end
        step(hold == 0, 1'b1);
        chk("resp_valid", if_id_reg.valid_s, 1'b1);
        chk("resp_busy", fetch_busy, 1'b1);
        chk("sb_nonempty", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        chk("pc_s", if_id_reg.pc_s, e[127:96]);
        chk("pc_next_s", if_id_reg.pc_next_s, e[95:64]);
        chk("order_s", if_id_reg.order_s, e[63:0]);
        if (hold > 0) begin
            chk("resp_rmask", imem_rmask, 4'h0);
            for (int h = 1; h <= hold; h++) begin
                step(1'b0, h == 1);
                chk("hold_valid", if_id_reg.valid_s, 1'b1);
                chk("hold_busy", fetch_busy, 1'b0);
                chk("hold_rmask", imem_rmask, 4'h0);
                chk("hold_pc_s", if_id_reg.pc_s, e[127:96]);
                chk("hold_order_s", if_id_reg.order_s, e[63:0]);
            end
            step(1'b1, 1'b0);
            chk("accept_valid", if_id_reg.valid_s, 1'b1);
            chk("accept_pc_next_s", if_id_reg.pc_next_s, e[95:64]);
        end
        m_pc    = m_pc + 32'd4;
        m_order = m_order + 64'd1;
`ifdef FETCH_PIPE_EN
        chk("adv_rmask", imem_rmask, 4'hF);
        chk("adv_addr", imem_addr, m_pc);
`else
        chk("adv_rmask", imem_rmask, 4'h0);
        step(1'b0, 1'b0);
`endif
    endtask

    // Directed sequence
    initial begin
        int t0;
        n_assert   = 0;
        n_fail     = 0;
        cyc        = 0;
        rst_n      = 1'b0;
        move       = 1'b0;
        imem_resp  = 1'b0;
        imem_rdata = 32'h0000_0013;
        move_b     = 1'b0;
        resp_b     = 1'b0;
        m_pc       = RST_PC_A;
        m_order    = 64'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_rmask", imem_rmask, 4'h0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_valid", if_id_reg.valid_s, 1'b0);
        chk("rst_busy", fetch_busy, 1'b0);
        chk("rst_state", dbg_state, S_REQ);
        chk("rst_rmask_b", rmask_b, 4'h0);

        // Release: the first cycle carries the request
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("first_req_b_addr", addr_b, RST_PC_B);
        chk("first_req_b_rmask", rmask_b, 4'hF);

        do_fetch(1, 0);
        do_fetch(1, 3);
        do_fetch(4, 0);

        // Sustained fetch against a 1-cycle memory
        t0 = cyc;
        for (int k = 0; k < 4; k++) do_fetch(1, 0);
        chk("throughput_cycles", 64'(cyc - t0), 64'(THR_EXP));

        for (int k = 0; k < 4; k++) begin
            do_fetch(int'($urandom_range(1, 3)), int'($urandom_range(0, 2)));
        end

        // Reset while a request is outstanding; a late response must be dropped
        step(1'b1, 1'b0);
        chk("pre_rst_busy", fetch_busy, 1'b1);
        chk("pre_rst_valid", if_id_reg.valid_s, 1'b0);
        @(negedge clk);
        rst_n     = 1'b0;
        move      = 1'b0;
        imem_resp = 1'b0;
        #1;
        chk("mid_rst_busy", fetch_busy, 1'b0);
        chk("mid_rst_rmask", imem_rmask, 4'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        move      = 1'b1;
        imem_resp = 1'b1;
        #1;
        m_pc    = RST_PC_A;
        m_order = 64'd0;
        exp_q.delete();
        do_fetch(2, 0);

        // PC wrap on the instance reset to the last word
        @(negedge clk);
        move_b = 1'b1;
        resp_b = 1'b1;
        #1;
        chk("wrap_valid", if_id_b.valid_s, 1'b1);
        chk("wrap_pc_s", if_id_b.pc_s, RST_PC_B);
        chk("wrap_pc_next_s", if_id_b.pc_next_s, 32'd0);
        chk("wrap_order_s", if_id_b.order_s, 64'd0);
`ifdef FETCH_PIPE_EN
        chk("wrap_addr", addr_b, 32'd0);
        chk("wrap_rmask", rmask_b, 4'hF);
`endif
        @(negedge clk);
        move_b = 1'b0;
        resp_b = 1'b0;
        #1;
`ifndef FETCH_PIPE_EN
        chk("wrap_addr", addr_b, 32'd0);
        chk("wrap_rmask", rmask_b, 4'hF);
`endif
        chk("wrap_valid_after", if_id_b.valid_s, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
